// File: rtl/alu_issue_if.sv
// Job-side and lane-side signal bundle of the dual-lane ALU issue buffer.
// The buffer uses the slave modport; the job source and lane consumer use master.
interface alu_issue_if #(
   parameter int N     = 16,
   parameter int OPN   = 3,
   parameter int DEPTH = 8,
   parameter int TAGW  = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_a;
   logic [N-1:0]    in_b;
   logic [N-1:0]    in_c;
   logic [OPN-1:0]  in_op1;
   logic [OPN-1:0]  in_op2;
   logic            stall;

   logic [N-1:0]    a_0;
   logic [N-1:0]    b_0;
   logic [N-1:0]    c_0;
   logic [OPN-1:0]  op1_0;
   logic [OPN-1:0]  op2_0;
   logic [N-1:0]    a_1;
   logic [N-1:0]    b_1;
   logic [N-1:0]    c_1;
   logic [OPN-1:0]  op1_1;
   logic [OPN-1:0]  op2_1;
   logic            iss_vld_0;
   logic            iss_vld_1;
   logic            res_vld_0;
   logic            res_vld_1;
   logic [TAGW-1:0] res_tag_0;
   logic [TAGW-1:0] res_tag_1;
   logic [LW-1:0]   level;

   modport slave (
      input  in_valid, in_a, in_b, in_c, in_op1, in_op2, stall,
      output in_ready,
      output a_0, b_0, c_0, op1_0, op2_0,
      output a_1, b_1, c_1, op1_1, op2_1,
      output iss_vld_0, iss_vld_1, res_vld_0, res_vld_1,
      output res_tag_0, res_tag_1, level
   );

   modport master (
      output in_valid, in_a, in_b, in_c, in_op1, in_op2, stall,
      input  in_ready,
      input  a_0, b_0, c_0, op1_0, op2_0,
      input  a_1, b_1, c_1, op1_1, op2_1,
      input  iss_vld_0, iss_vld_1, res_vld_0, res_vld_1,
      input  res_tag_0, res_tag_1, level
   );
endinterface

// File: rtl/alu_issue.sv
// Dual-lane issue buffer: FIFO of ALU jobs, up to two issued per cycle (oldest on lane 0),
// with a LAT-deep {valid, tag} shadow pipeline marking which z_0/z_1 results are real.
module alu_issue #(
   parameter int N     = 16,
   parameter int OPN   = 3,
   parameter int DEPTH = 8,
   parameter int LAT   = 3,
   parameter int TAGW  = 4
) (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [OPN-1:0] op1;
      logic [OPN-1:0] op2;
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [N-1:0]   c;
   } job_t;

   typedef struct packed {
      logic            vld;
      logic [TAGW-1:0] tag;
   } trk_t;

   job_t mem [DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [TAGW-1:0] tag_q, tag_d;
   job_t            lane_q [2];
   job_t            lane_d [2];
   trk_t            iss_q  [2];
   trk_t            iss_d  [2];
   trk_t            pipe_q [2][LAT];
   trk_t            pipe_d [2][LAT];

   logic            push;
   logic [1:0]      k;
   job_t            in_job;

   assign in_job = '{op1: bus.in_op1, op2: bus.in_op2, a: bus.in_a, b: bus.in_b, c: bus.in_c};

   // Issue count comes from the registered level only, so a job pushed this edge waits one cycle.
   always_comb begin
      push     = bus.in_valid && (level_q < LW'(DEPTH));
      k        = 2'd0;
      if (!bus.stall) begin
         k = (level_q >= LW'(2)) ? 2'd2 : level_q[1:0];
      end
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(k);
      level_d  = level_q + LW'(push) - LW'(k);
      tag_d    = tag_q + TAGW'(k);

      lane_d[0] = '0;
      lane_d[1] = '0;
      iss_d[0]  = '0;
      iss_d[1]  = '0;
      if (k != 2'd0) begin
         lane_d[0] = mem[rd_ptr_q];
         iss_d[0]  = '{vld: 1'b1, tag: tag_q};
      end
      if (k == 2'd2) begin
         lane_d[1] = mem[rd_ptr_q + PW'(1)];
         iss_d[1]  = '{vld: 1'b1, tag: tag_q + TAGW'(1)};
      end
   end

   // The tracking pipeline runs freely: the ALU itself never stalls.
   always_comb begin
      for (int l = 0; l < 2; l++) begin
         for (int s = 0; s < LAT; s++) begin
            pipe_d[l][s] = (s == 0) ? iss_q[l] : pipe_q[l][(s == 0) ? 0 : s - 1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= in_job;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         tag_q    <= '0;
         for (int l = 0; l < 2; l++) begin
            lane_q[l] <= '0;
            iss_q[l]  <= '0;
            for (int s = 0; s < LAT; s++) begin
               pipe_q[l][s] <= '0;
            end
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         tag_q    <= tag_d;
         for (int l = 0; l < 2; l++) begin
            lane_q[l] <= lane_d[l];
            iss_q[l]  <= iss_d[l];
            for (int s = 0; s < LAT; s++) begin
               pipe_q[l][s] <= pipe_d[l][s];
            end
         end
      end
   end

   assign bus.in_ready  = (level_q < LW'(DEPTH));
   assign bus.level     = level_q;
   assign bus.a_0       = lane_q[0].a;
   assign bus.b_0       = lane_q[0].b;
   assign bus.c_0       = lane_q[0].c;
   assign bus.op1_0     = lane_q[0].op1;
   assign bus.op2_0     = lane_q[0].op2;
   assign bus.a_1       = lane_q[1].a;
   assign bus.b_1       = lane_q[1].b;
   assign bus.c_1       = lane_q[1].c;
   assign bus.op1_1     = lane_q[1].op1;
   assign bus.op2_1     = lane_q[1].op2;
   assign bus.iss_vld_0 = iss_q[0].vld;
   assign bus.iss_vld_1 = iss_q[1].vld;
   assign bus.res_vld_0 = pipe_q[0][LAT-1].vld;
   assign bus.res_vld_1 = pipe_q[1][LAT-1].vld;
   assign bus.res_tag_0 = pipe_q[0][LAT-1].tag;
   assign bus.res_tag_1 = pipe_q[1][LAT-1].tag;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: inputs driven and outputs sampled on the falling clock edge.
module tb_alu_issue;
   localparam int N = 16, OPN = 3, DEPTH = 8, LAT = 3, TAGW = 4;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [2:0]  op1;
      logic [2:0]  op2;
   } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_issue_if #(.N(N), .OPN(OPN), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();

   alu_issue #(.N(N), .OPN(OPN), .DEPTH(DEPTH), .LAT(LAT), .TAGW(TAGW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic drive_job(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [2:0] o1, input logic [2:0] o2);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_c     = c;
      bus.in_op1   = o1;
      bus.in_op2   = o2;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      bus.stall = 1'b0;
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.stall = 1'b0;
      drive_job(1'b1, 16'h1234, 16'h5678, 16'h9abc, 3'd5, 3'd6);
      @(negedge clk);
      checks++;
      if (bus.level !== 4'd0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_level: level=%0d in_ready=%0b, required 0/1", bus.level, bus.in_ready);
      end
      checks++;
      if ({bus.iss_vld_0, bus.iss_vld_1, bus.res_vld_0, bus.res_vld_1} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_valids: iss=%b%b res=%b%b, required all 0",
                  bus.iss_vld_0, bus.iss_vld_1, bus.res_vld_0, bus.res_vld_1);
      end
      checks++;
      if ({bus.a_0, bus.b_0, bus.c_0, bus.op1_0, bus.op2_0, bus.a_1, bus.op1_1,
           bus.res_tag_0, bus.res_tag_1} !== '0) begin
         errors++;
         $display("FAIL reset_data: a_0=%h op1_0=%0d a_1=%h tag0=%0d tag1=%0d, required 0",
                  bus.a_0, bus.op1_0, bus.a_1, bus.res_tag_0, bus.res_tag_1);
      end
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single();
      apply_reset();
      drive_job(1'b1, 16'h0011, 16'h0022, 16'h0003, 3'd1, 3'd2);
      @(negedge clk);
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      checks++;
      if (bus.level !== 4'd1 || bus.iss_vld_0 !== 1'b0) begin
         errors++;
         $display("FAIL single_push: level=%0d iss_vld_0=%0b, required 1/0", bus.level, bus.iss_vld_0);
      end
      @(negedge clk);
      checks++;
      if ({bus.a_0, bus.b_0, bus.c_0, bus.op1_0, bus.op2_0} !== {16'h0011, 16'h0022, 16'h0003, 3'd1, 3'd2}) begin
         errors++;
         $display("FAIL single_lane0: a=%h b=%h c=%h op1=%0d op2=%0d, required 0011 0022 0003 1 2",
                  bus.a_0, bus.b_0, bus.c_0, bus.op1_0, bus.op2_0);
      end
      checks++;
      if (bus.iss_vld_0 !== 1'b1 || bus.iss_vld_1 !== 1'b0 || bus.a_1 !== 16'h0 || bus.level !== 4'd0) begin
         errors++;
         $display("FAIL single_issue: iss=%b%b a_1=%h level=%0d, required 1 0 0000 0",
                  bus.iss_vld_0, bus.iss_vld_1, bus.a_1, bus.level);
      end
      for (int e = 3; e <= 4; e++) begin
         @(negedge clk);
         checks++;
         if (bus.res_vld_0 !== 1'b0 || bus.iss_vld_0 !== 1'b0) begin
            errors++;
            $display("FAIL single_early_e%0d: res_vld_0=%0b iss_vld_0=%0b, required 0/0",
                     e, bus.res_vld_0, bus.iss_vld_0);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.res_vld_0 !== 1'b1 || bus.res_tag_0 !== 4'd0 || bus.res_vld_1 !== 1'b0) begin
         errors++;
         $display("FAIL single_result: res_vld_0=%0b tag0=%0d res_vld_1=%0b, required 1 0 0",
                  bus.res_vld_0, bus.res_tag_0, bus.res_vld_1);
      end
      @(negedge clk);
      checks++;
      if (bus.res_vld_0 !== 1'b0) begin
         errors++;
         $display("FAIL single_result_end: res_vld_0=%0b, required 0", bus.res_vld_0);
      end
      $display("test_single done");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      bus.stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready_%0d: in_ready=%0b, required 1", i, bus.in_ready);
         end
         drive_job(1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i), 3'(i), 3'(7 - i));
         @(negedge clk);
      end
      checks++;
      if (bus.level !== 4'd8 || bus.in_ready !== 1'b0 || bus.iss_vld_0 !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: level=%0d in_ready=%0b iss_vld_0=%0b, required 8 0 0",
                  bus.level, bus.in_ready, bus.iss_vld_0);
      end
      drive_job(1'b1, 16'hBAD0, 16'hBAD1, 16'hBAD2, 3'd7, 3'd7);
      @(negedge clk);
      checks++;
      if (bus.level !== 4'd8) begin
         errors++;
         $display("FAIL fill_ninth: level=%0d, required 8", bus.level);
      end
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      bus.stall = 1'b0;
      for (int t = 0; t < 7; t++) begin
         @(negedge clk);
         if (t < 4) begin
            checks++;
            if ({bus.iss_vld_1, bus.iss_vld_0} !== 2'b11 || bus.a_0 !== 16'h0100 + 16'(2 * t) ||
                bus.a_1 !== 16'h0101 + 16'(2 * t) || bus.level !== 4'(6 - 2 * t)) begin
               errors++;
               $display("FAIL pair_issue_%0d: iss=%b%b a_0=%h a_1=%h level=%0d, required 11 %h %h %0d",
                        t, bus.iss_vld_1, bus.iss_vld_0, bus.a_0, bus.a_1, bus.level,
                        16'h0100 + 16'(2 * t), 16'h0101 + 16'(2 * t), 6 - 2 * t);
            end
         end else begin
            checks++;
            if ({bus.iss_vld_1, bus.iss_vld_0} !== 2'b00) begin
               errors++;
               $display("FAIL pair_drained_%0d: iss=%b%b, required 00", t, bus.iss_vld_1, bus.iss_vld_0);
            end
         end
         if (t >= 3) begin
            checks++;
            if ({bus.res_vld_1, bus.res_vld_0} !== 2'b11 || bus.res_tag_0 !== 4'(2 * (t - 3)) ||
                bus.res_tag_1 !== 4'(2 * (t - 3) + 1)) begin
               errors++;
               $display("FAIL pair_result_%0d: res=%b%b tags=%0d,%0d, required 11 %0d,%0d",
                        t, bus.res_vld_1, bus.res_vld_0, bus.res_tag_0, bus.res_tag_1,
                        2 * (t - 3), 2 * (t - 3) + 1);
            end
         end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_stream();
      apply_reset();
      drive_job(1'b1, 16'h0200, 16'h0, 16'h0, 3'd0, 3'd0);
      for (int t = 0; t < 14; t++) begin
         @(negedge clk);
         checks++;
         if (bus.level > 4'd1 || bus.iss_vld_1 !== 1'b0 || bus.res_vld_1 !== 1'b0) begin
            errors++;
            $display("FAIL stream_lane1_%0d: level=%0d iss_vld_1=%0b res_vld_1=%0b, required <=1 0 0",
                     t, bus.level, bus.iss_vld_1, bus.res_vld_1);
         end
         if (t >= 1 && t <= 10) begin
            checks++;
            if (bus.iss_vld_0 !== 1'b1 || bus.a_0 !== 16'h0200 + 16'(t - 1)) begin
               errors++;
               $display("FAIL stream_issue_%0d: iss_vld_0=%0b a_0=%h, required 1 %h",
                        t, bus.iss_vld_0, bus.a_0, 16'h0200 + 16'(t - 1));
            end
         end
         if (t >= 4) begin
            checks++;
            if (bus.res_vld_0 !== 1'b1 || bus.res_tag_0 !== 4'(t - 4)) begin
               errors++;
               $display("FAIL stream_result_%0d: res_vld_0=%0b tag0=%0d, required 1 %0d",
                        t, bus.res_vld_0, bus.res_tag_0, t - 4);
            end
         end
         if (t < 9) drive_job(1'b1, 16'h0201 + 16'(t), 16'h0, 16'h0, 3'd0, 3'd0);
         else       drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      end
      $display("test_stream done");
   endtask

   function automatic job_t mk_job(input int i);
      mk_job = '{a: 16'h3000 + 16'(i), b: 16'hA000 ^ 16'(i), c: 16'(i * 7),
                 op1: 3'(i), op2: 3'(i + 3)};
   endfunction

   task automatic test_wrap();
      job_t       exp_q[$];
      logic [3:0] tag_q[$];
      job_t       got;
      job_t       nxt;
      int         pushed  = 0;
      int         issued  = 0;
      int         results = 0;
      logic [3:0] last_tag = 4'd0;
      apply_reset();
      for (int t = 0; t < 200 && !(pushed == 20 && results == 20); t++) begin
         @(negedge clk);
         checks++;
         if (bus.iss_vld_1 === 1'b1 && bus.iss_vld_0 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_lane_order_%0d: iss=%b%b, required lane 0 used first",
                     t, bus.iss_vld_1, bus.iss_vld_0);
         end
         for (int l = 0; l < 2; l++) begin
            if ((l == 0) ? bus.iss_vld_0 : bus.iss_vld_1) begin
               got = (l == 0) ? '{bus.a_0, bus.b_0, bus.c_0, bus.op1_0, bus.op2_0}
                              : '{bus.a_1, bus.b_1, bus.c_1, bus.op1_1, bus.op2_1};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL wrap_extra_issue_l%0d: a=%h, required no issue", l, got.a);
               end else begin
                  nxt = exp_q.pop_front();
                  if (got !== nxt) begin
                     errors++;
                     $display("FAIL wrap_data_%0d_l%0d: got %h, required %h", issued, l, got, nxt);
                  end
               end
               tag_q.push_back(4'(issued));
               issued++;
            end
         end
         for (int l = 0; l < 2; l++) begin
            if ((l == 0) ? bus.res_vld_0 : bus.res_vld_1) begin
               last_tag = (l == 0) ? bus.res_tag_0 : bus.res_tag_1;
               checks++;
               if (tag_q.size() == 0) begin
                  errors++;
                  $display("FAIL wrap_extra_result_l%0d: tag=%0d, required no result", l, last_tag);
               end else if (last_tag !== tag_q[0]) begin
                  errors++;
                  $display("FAIL wrap_tag_%0d_l%0d: tag=%0d, required %0d", results, l, last_tag, tag_q[0]);
                  void'(tag_q.pop_front());
               end else begin
                  void'(tag_q.pop_front());
               end
               results++;
            end
         end
         bus.stall = (t % 3 == 0);
         if (pushed < 20) begin
            nxt = mk_job(pushed);
            drive_job(1'b1, nxt.a, nxt.b, nxt.c, nxt.op1, nxt.op2);
            if (bus.in_ready) begin
               exp_q.push_back(nxt);
               pushed++;
            end
         end else begin
            drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
         end
      end
      bus.stall = 1'b0;
      checks++;
      if (results != 20 || issued != 20 || last_tag !== 4'd3) begin
         errors++;
         $display("FAIL wrap_totals: issued=%0d results=%0d last_tag=%0d, required 20 20 3",
                  issued, results, last_tag);
      end
      $display("test_wrap done");
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.stall = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive_job(1'b1, 16'h0700 + 16'(i), 16'h0, 16'h0, 3'd0, 3'd0);
         @(negedge clk);
      end
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      bus.stall = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.iss_vld_1, bus.iss_vld_0} !== 2'b11 || bus.level !== 4'd5) begin
         errors++;
         $display("FAIL mid_pre: iss=%b%b level=%0d, required 11 5", bus.iss_vld_1, bus.iss_vld_0, bus.level);
      end
      bus.stall = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.level !== 4'd0 || bus.in_ready !== 1'b1 ||
          {bus.iss_vld_0, bus.iss_vld_1, bus.res_vld_0, bus.res_vld_1} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset: level=%0d in_ready=%0b iss=%b%b res=%b%b, required 0 1 00 00",
                  bus.level, bus.in_ready, bus.iss_vld_0, bus.iss_vld_1, bus.res_vld_0, bus.res_vld_1);
      end
      @(negedge clk);
      rst       = 1'b0;
      bus.stall = 1'b0;
      for (int t = 0; t < LAT + 1; t++) begin
         @(negedge clk);
         checks++;
         if ({bus.iss_vld_0, bus.iss_vld_1, bus.res_vld_0, bus.res_vld_1} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_quiet_%0d: iss=%b%b res=%b%b, required all 0",
                     t, bus.iss_vld_0, bus.iss_vld_1, bus.res_vld_0, bus.res_vld_1);
         end
      end
      drive_job(1'b1, 16'h0ABC, 16'h0, 16'h0, 3'd0, 3'd0);
      @(negedge clk);
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      @(negedge clk);
      checks++;
      if (bus.iss_vld_0 !== 1'b1 || bus.a_0 !== 16'h0ABC) begin
         errors++;
         $display("FAIL mid_next_issue: iss_vld_0=%0b a_0=%h, required 1 0abc", bus.iss_vld_0, bus.a_0);
      end
      repeat (LAT) @(negedge clk);
      checks++;
      if (bus.res_vld_0 !== 1'b1 || bus.res_tag_0 !== 4'd0) begin
         errors++;
         $display("FAIL mid_next_tag: res_vld_0=%0b tag0=%0d, required 1 0", bus.res_vld_0, bus.res_tag_0);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_odd();
      apply_reset();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_job(1'b1, 16'h0E00 + 16'(i), 16'h0F00 + 16'(i), 16'h0D00 + 16'(i), 3'(i + 1), 3'(i + 2));
         @(negedge clk);
      end
      drive_job(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
      bus.stall = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.iss_vld_1, bus.iss_vld_0} !== 2'b11 || bus.a_0 !== 16'h0E00 || bus.a_1 !== 16'h0E01 ||
          bus.op1_1 !== 3'd2 || bus.level !== 4'd1) begin
         errors++;
         $display("FAIL odd_pair: iss=%b%b a_0=%h a_1=%h op1_1=%0d level=%0d, required 11 0e00 0e01 2 1",
                  bus.iss_vld_1, bus.iss_vld_0, bus.a_0, bus.a_1, bus.op1_1, bus.level);
      end
      @(negedge clk);
      checks++;
      if (bus.iss_vld_0 !== 1'b1 || bus.a_0 !== 16'h0E02 || bus.c_0 !== 16'h0D02 || bus.iss_vld_1 !== 1'b0 ||
          {bus.a_1, bus.b_1, bus.c_1, bus.op1_1, bus.op2_1} !== '0 || bus.level !== 4'd0) begin
         errors++;
         $display("FAIL odd_single: iss=%b%b a_0=%h c_0=%h a_1=%h b_1=%h op2_1=%0d level=%0d, required 01 0e02 0d02 0 0 0 0",
                  bus.iss_vld_1, bus.iss_vld_0, bus.a_0, bus.c_0, bus.a_1, bus.b_1, bus.op2_1, bus.level);
      end
      $display("test_odd done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stream();
      test_wrap();
      test_reset_mid();
      test_odd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
